// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer driving the CSR unit: MEPC/MCAUSE writes, MTVEC read, PC redirect; MRET via MEPC read.
// Optional TRAP_VEC_SCALE_EN: trap target = VEC_BASE + (mtvec << 2).
module trap_sequencer #(
   parameter int                    MXLEN      = 32,
   parameter int                    ADDR_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] MTVEC      = 12'h305,
   parameter logic [ADDR_WIDTH-1:0] MEPC       = 12'h341,
   parameter logic [ADDR_WIDTH-1:0] MCAUSE     = 12'h342,
   parameter logic [MXLEN-1:0]      VEC_BASE   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trap_req,
   input  logic [MXLEN-1:0]      trap_cause,
   input  logic [MXLEN-1:0]      trap_pc,
   input  logic                  mret_req,
   input  logic [MXLEN-1:0]      csr_rdata,
   input  logic                  csr_error,
   output logic                  csr_excp_int,
   output logic                  csr_op,
   output logic [ADDR_WIDTH-1:0] csr_addr,
   output logic [MXLEN-1:0]      csr_wdata,
   output logic                  busy,
   output logic                  redirect_valid,
   output logic [MXLEN-1:0]      redirect_pc,
   output logic                  trap_fault
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_EPC, S_WR_CAUSE, S_RD_VEC, S_VEC_WAIT,
      S_MRET_RD, S_MRET_WAIT, S_REDIRECT, S_FAULT
   } state_t;

   state_t                state_q, state_d;
   logic [MXLEN-1:0]      pc_q, pc_d, cause_q, cause_d, target_q, target_d;
   logic                  excp_q, excp_d, op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [MXLEN-1:0]      wdata_q, wdata_d;
   logic                  busy_q, busy_d, rv_q, rv_d, fault_q, fault_d;
   logic [MXLEN-1:0]      vec_target;

`ifdef TRAP_VEC_SCALE_EN
   assign vec_target = VEC_BASE + (csr_rdata << 2);
`else
   logic [MXLEN-1:0] unused_vec_base;
   assign unused_vec_base = VEC_BASE;
   assign vec_target      = csr_rdata;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cause_d  = cause_q;
      target_d = target_q;
      case (state_q)
         S_IDLE: begin
            if (trap_req) begin
               pc_d    = trap_pc;
               cause_d = trap_cause;
               state_d = S_WR_EPC;
            end else if (mret_req) begin
               state_d = S_MRET_RD;
            end
         end
         S_WR_EPC:   state_d = S_WR_CAUSE;
         // csr_error here reflects the access issued in the previous state
         S_WR_CAUSE: state_d = csr_error ? S_FAULT : S_RD_VEC;
         S_RD_VEC:   state_d = csr_error ? S_FAULT : S_VEC_WAIT;
         S_VEC_WAIT: begin
            if (csr_error) state_d = S_FAULT;
            else begin
               target_d = vec_target;
               state_d  = S_REDIRECT;
            end
         end
         S_MRET_RD:  state_d = S_MRET_WAIT;
         S_MRET_WAIT: begin
            if (csr_error) state_d = S_FAULT;
            else begin
               target_d = csr_rdata;
               state_d  = S_REDIRECT;
            end
         end
         default:    state_d = S_IDLE;
      endcase

      // Outputs decoded from the next state so they are registered alongside it
      excp_d  = 1'b0;
      op_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      case (state_d)
         S_WR_EPC:   begin excp_d = 1'b1; op_d = 1'b1; addr_d = MEPC;   wdata_d = pc_d;    end
         S_WR_CAUSE: begin excp_d = 1'b1; op_d = 1'b1; addr_d = MCAUSE; wdata_d = cause_d; end
         S_RD_VEC:   begin excp_d = 1'b1; addr_d = MTVEC; end
         S_MRET_RD:  begin excp_d = 1'b1; addr_d = MEPC;  end
         default: ;
      endcase
      busy_d  = (state_d != S_IDLE);
      rv_d    = (state_d == S_REDIRECT);
      fault_d = (state_d == S_FAULT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         cause_q  <= '0;
         target_q <= '0;
         excp_q   <= 1'b0;
         op_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cause_q  <= cause_d;
         target_q <= target_d;
         excp_q   <= excp_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         rv_q     <= rv_d;
         fault_q  <= fault_d;
      end
   end

   assign csr_excp_int   = excp_q;
   assign csr_op         = op_q;
   assign csr_addr       = addr_q;
   assign csr_wdata      = wdata_q;
   assign busy           = busy_q;
   assign redirect_valid = rv_q;
   assign redirect_pc    = target_q;
   assign trap_fault     = fault_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: registered CSR model plus a scoreboard of expected CSR accesses and redirect timing.
module tb_trap_sequencer;
   localparam logic [31:0] VEC_BASE_TB = 32'h1000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        trap_req = 1'b0, mret_req = 1'b0, csr_error = 1'b0;
   logic [31:0] trap_cause = '0, trap_pc = '0, csr_rdata = '0;
   logic        csr_excp_int, csr_op, busy, redirect_valid, trap_fault;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, redirect_pc;

   trap_sequencer #(.VEC_BASE(VEC_BASE_TB)) dut (
      .clk(clk), .rst(rst), .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .mret_req(mret_req), .csr_rdata(csr_rdata), .csr_error(csr_error),
      .csr_excp_int(csr_excp_int), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_fault(trap_fault)
   );

   always #5 clk = ~clk;

   // Registered CSR unit model
   logic [31:0] m_mepc = '0, m_mcause = '0, mtvec_val = '0;
   logic [11:0] err_addr = 12'hFFF;
   always @(posedge clk) begin
      csr_rdata <= '0;
      csr_error <= 1'b0;
      if (csr_excp_int) begin
         if (csr_op) begin
            if (csr_addr == 12'h341) m_mepc <= csr_wdata;
            else if (csr_addr == 12'h342) m_mcause <= csr_wdata;
         end else begin
            csr_rdata <= (csr_addr == 12'h305) ? mtvec_val : (csr_addr == 12'h341) ? m_mepc : '0;
         end
         csr_error <= (csr_addr == err_addr);
      end
   end

   typedef struct packed {
      logic        op;
      logic [11:0] addr;
      logic [31:0] wdata;
   } acc_t;

   acc_t        exp_q[$];
   int          checks = 0, errors = 0;
   logic [31:0] exp_mepc = '0;

   function automatic logic [31:0] trap_target(input logic [31:0] v);
`ifdef TRAP_VEC_SCALE_EN
      return VEC_BASE_TB + (v << 2);
`else
      return v;
`endif
   endfunction

   task automatic run_case(input string name, input logic is_trap, input logic also_mret,
                           input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] vec,
                           input logic [11:0] err, input int mret_pulse_c);
      int          end_c;
      logic        exp_fault, seen;
      logic [31:0] exp_pc;
      acc_t        a;
      mtvec_val = vec;
      err_addr  = err;
      exp_q.delete();
      exp_fault = 1'b0;
      exp_pc    = '0;
      if (is_trap) begin
         exp_q.push_back('{1'b1, 12'h341, pc});
         exp_q.push_back('{1'b1, 12'h342, cause});
         if (err == 12'h341) begin
            end_c = 3; exp_fault = 1'b1;
         end else begin
            exp_q.push_back('{1'b0, 12'h305, 32'h0});
            end_c = (err == 12'h342) ? 4 : 5;
            exp_fault = (err == 12'h342) || (err == 12'h305);
            exp_pc = trap_target(vec);
         end
         exp_mepc = pc;
      end else begin
         exp_q.push_back('{1'b0, 12'h341, 32'h0});
         end_c = 3;
         exp_fault = (err == 12'h341);
         exp_pc = exp_mepc;
      end
      trap_req = is_trap; trap_pc = pc; trap_cause = cause;
      mret_req = also_mret || !is_trap;
      seen = 1'b0;
      for (int c = 1; c <= end_c + 1; c++) begin
         @(negedge clk);
         if (mret_pulse_c > 0 && c == mret_pulse_c) mret_req = 1'b1;
         else if (mret_pulse_c > 0 && c == mret_pulse_c + 1) mret_req = 1'b0;
         checks++;
         if (busy !== (c <= end_c)) begin
            errors++; $display("FAIL %s busy c%0d: got %b expected %b", name, c, busy, c <= end_c);
         end
         if (csr_excp_int) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL %s extra csr access c%0d: got addr %h expected none", name, c, csr_addr);
            end else begin
               a = exp_q.pop_front();
               if ({csr_op, csr_addr, csr_wdata} !== a) begin
                  errors++;
                  $display("FAIL %s csr access c%0d: got op %b addr %h wdata %h expected op %b addr %h wdata %h",
                           name, c, csr_op, csr_addr, csr_wdata, a.op, a.addr, a.wdata);
               end
            end
         end
         if (redirect_valid || trap_fault) begin
            checks++;
            if (c != end_c || redirect_valid !== !exp_fault || trap_fault !== exp_fault) begin
               errors++;
               $display("FAIL %s completion: got c%0d rv %b fault %b expected c%0d rv %b fault %b",
                        name, c, redirect_valid, trap_fault, end_c, !exp_fault, exp_fault);
            end
            if (!exp_fault) begin
               checks++;
               if (redirect_pc !== exp_pc) begin
                  errors++; $display("FAIL %s redirect_pc: got %h expected %h", name, redirect_pc, exp_pc);
               end
            end
            trap_req = 1'b0; mret_req = 1'b0; seen = 1'b1;
         end
      end
      trap_req = 1'b0; mret_req = 1'b0;
      checks++;
      if (!seen || exp_q.size() != 0) begin
         errors++; $display("FAIL %s missing events: got seen %b pending %0d expected seen 1 pending 0",
                            name, seen, exp_q.size());
      end
      err_addr = 12'hFFF;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({csr_excp_int, csr_op, csr_addr, csr_wdata, busy, redirect_valid, redirect_pc, trap_fault} !== '0) begin
         errors++; $display("FAIL reset_state: got busy %b addr %h pc %h expected all 0", busy, csr_addr, redirect_pc);
      end
      rst = 1'b0;
      trap_req = 1'b1; trap_pc = 32'h100; trap_cause = 32'h2;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (csr_addr !== 12'h342) begin
         errors++; $display("FAIL reset_pre_wr_cause: got addr %h expected 342", csr_addr);
      end
      exp_mepc = 32'h100;
      rst = 1'b1; trap_req = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({csr_excp_int, csr_op, csr_addr, csr_wdata, busy, redirect_valid, redirect_pc, trap_fault} !== '0) begin
            errors++; $display("FAIL reset_mid_seq c%0d: got busy %b excp %b expected all 0", c, busy, csr_excp_int);
         end
      end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if ({busy, redirect_valid, trap_fault} !== 3'b000) begin
            errors++; $display("FAIL reset_after c%0d: got busy/rv/fault %b expected 000", c, {busy, redirect_valid, trap_fault});
         end
      end
   endtask

   task automatic test_trap();         run_case("trap", 1'b1, 1'b0, 32'h100, 32'h2, 32'hB4, 12'hFFF, 0); endtask
   task automatic test_mret();         run_case("mret", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 12'hFFF, 0); endtask
   task automatic test_simultaneous(); run_case("simul", 1'b1, 1'b1, 32'h200, 32'hB, 32'h40, 12'hFFF, 0); endtask
   task automatic test_error();
      run_case("err_cause", 1'b1, 1'b0, 32'h300, 32'h7, 32'h80, 12'h342, 0);
      run_case("after_err", 1'b1, 1'b0, 32'h104, 32'h3, 32'h10, 12'hFFF, 0);
      run_case("err_epc", 1'b1, 1'b0, 32'h308, 32'h4, 32'h80, 12'h341, 0);
      run_case("err_vec", 1'b1, 1'b0, 32'h30C, 32'h5, 32'h80, 12'h305, 0);
      run_case("err_mret", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 12'h341, 0);
   endtask
   task automatic test_busy_drop();    run_case("busy_drop", 1'b1, 1'b0, 32'h400, 32'h5, 32'h20, 12'hFFF, 3); endtask

   task automatic test_back_to_back();
      logic exp_busy, exp_rv;
      acc_t a;
      exp_q.delete();
      exp_q.push_back('{1'b0, 12'h341, 32'h0});
      exp_q.push_back('{1'b0, 12'h341, 32'h0});
      mret_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 5) mret_req = 1'b0;
         exp_busy = (c != 4) && (c != 8);
         exp_rv   = (c == 3) || (c == 7);
         checks++;
         if (busy !== exp_busy || redirect_valid !== exp_rv || trap_fault !== 1'b0) begin
            errors++; $display("FAIL b2b c%0d: got busy %b rv %b fault %b expected busy %b rv %b fault 0",
                               c, busy, redirect_valid, trap_fault, exp_busy, exp_rv);
         end
         if (exp_rv) begin
            checks++;
            if (redirect_pc !== exp_mepc) begin
               errors++; $display("FAIL b2b redirect_pc c%0d: got %h expected %h", c, redirect_pc, exp_mepc);
            end
         end
         if (csr_excp_int) begin
            checks++;
            a = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            if ({csr_op, csr_addr, csr_wdata} !== a) begin
               errors++; $display("FAIL b2b csr access c%0d: got addr %h wdata %h expected addr %h wdata %h",
                                  c, csr_addr, csr_wdata, a.addr, a.wdata);
            end
         end
      end
      mret_req = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL b2b pending: got %0d expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_trap();
      test_mret();
      test_simultaneous();
      test_error();
      test_busy_drop();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
